// File: rtl/dsp_result_drain.sv
// dsp_result_drain: consumes the resulta output of dsp_slice. A valid-bit delay line marks
// the cycles that carry real results. Each marked result is rounded, shifted and saturated,
// then pushed into a show-ahead FIFO that is drained through a valid/ready handshake.
//
// Ports:
//   clk, clr_n   clock, async active-low reset
//   flush        synchronous clear of delay line, FIFO and status
//   issue_valid  operands entered the slice this cycle
//   issue_ready  advisory credit: level + inflight < DEPTH
//   result_in    raw slice result (signed, IN_W)
//   out_data     FIFO head (signed, OUT_W), zero while empty
//   out_sat      head entry was saturated
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts head
//   overflow     sticky: a valid result was dropped
//   drop_count   dropped results, saturating
//   level        FIFO occupancy
module dsp_result_drain #(
  parameter int unsigned IN_W    = 37,
  parameter int unsigned OUT_W   = 18,
  parameter int unsigned SHIFT   = 18,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [IN_W-1:0]            result_in,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned IFW = $clog2(LATENCY + 1);
  localparam int unsigned RndSh = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Rounding constant 2^(SHIFT-1), or zero when no shift is applied.
  localparam logic signed [IN_W:0] RndK =
    (SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RndSh) : '0;
  // OUT_W signed limits, sign-extended to the internal IN_W+1 width.
  localparam logic signed [IN_W:0] SatMax = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SatMin = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Valid delay line and in-flight counter
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] dl_q, dl_d;
  logic [IFW-1:0]     inflight_q, inflight_d;
  logic               capture;

  assign capture = dl_q[LATENCY-1];

  always_comb begin
    dl_d       = LATENCY'({dl_q, issue_valid});
    inflight_d = inflight_q + IFW'(issue_valid) - IFW'(capture);
    if (flush) begin
      dl_d       = '0;
      inflight_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Round, shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [IN_W:0] ext, sum, shr;
  logic                 sat_hi, sat_lo;
  logic [OUT_W-1:0]     res_data;
  logic                 res_sat;

  always_comb begin
    ext    = {result_in[IN_W-1], result_in};
    // One extra bit of headroom, so adding the rounding constant cannot wrap.
    sum    = ext + RndK;
    shr    = sum >>> SHIFT;
    sat_hi = shr > SatMax;
    sat_lo = shr < SatMin;
    res_sat = sat_hi | sat_lo;
    if (sat_hi) begin
      res_data = SatMax[OUT_W-1:0];
    end else if (sat_lo) begin
      res_data = SatMin[OUT_W-1:0];
    end else begin
      res_data = shr[OUT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]    mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              full, pop, push, drop;

  assign full = (level_q == LW'(DEPTH));
  assign pop  = out_valid & out_ready & ~flush;
  // A pop in the same cycle frees the slot a full FIFO needs for the new entry.
  assign push = capture & ~flush & (~full | pop);
  assign drop = capture & ~flush & full & ~pop;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop) level_d = level_q + LW'(1);
      if (pop && !push) level_d = level_q - LW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dl_q       <= '0;
      inflight_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      dl_q       <= dl_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {res_sat, res_data};
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [OUT_W:0] head;

  assign head        = mem_q[rptr_q];
  assign out_valid   = (level_q != '0);
  assign out_data    = out_valid ? head[OUT_W-1:0] : '0;
  assign out_sat     = out_valid & head[OUT_W];
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign issue_ready = (32'(level_q) + 32'(inflight_q)) < DEPTH;

endmodule
